// File: rtl/mac_result_fifo.sv
// Result FIFO behind the sum-of-squares MAC: 1-cycle show-ahead, never stalls the MAC; overflow drops and sets sticky drop.
// Optional accumulator roll-over tagging is compiled in with `define MAC_FIFO_WRAP_DETECT_EN.
module mac_result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop,
    output logic                       out_wrap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_drop;

    logic w_nonempty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_nonempty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = in_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            if (in_valid && !w_push)
                r_drop <= 1'b1;
        end
    end

    // Storage needs no reset; the output mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

    assign out_valid = w_nonempty;
    assign out_data  = w_nonempty ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign drop      = r_drop;

`ifdef MAC_FIFO_WRAP_DETECT_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_tag [DEPTH];

    // prev tracks every valid MAC result, including ones that were dropped.
    always_ff @(posedge clk) begin
        if (reset)
            r_prev <= '0;
        else if (in_valid)
            r_prev <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_tag[r_wr_ptr] <= (in_data < r_prev);
    end

    assign out_wrap = w_nonempty ? r_tag[r_rd_ptr] : 1'b0;
`else
    assign out_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// Bench for mac_result_fifo: table of per-cycle vectors with expected count/valid/drop, data and wrap tags via a scoreboard queue.
module tb_mac_result_fifo;
    localparam int WIDTH = 20;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             drop;
    logic             out_wrap;

    mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .drop      (drop),
        .out_wrap  (out_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             rdy;
        int               cnt;   // -1: take count/drop from the model
        logic             vld;
        logic             drp;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb_dat[$];
    logic             sb_tag[$];
    logic [WIDTH-1:0] m_prev;
    logic             m_drop;
    int               n_vec = 0;
    int               n_err = 0;

`ifdef MAC_FIFO_WRAP_DETECT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    function automatic vec_t mk(input logic rst, input logic iv, input int id, input logic rdy,
                                input int cnt, input logic vld, input logic drp);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = WIDTH'(id); v.rdy = rdy;
        v.cnt = cnt; v.vld = vld; v.drp = drp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic             pop;
        int               exp_cnt;
        logic             exp_vld;
        logic             exp_drp;
        @(negedge clk);
        reset     = v.rst;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.rdy;
        #1;
        pop = !v.rst && v.rdy && (sb_dat.size() > 0);
        if (pop) begin
            check("pop_data", 32'(out_data), 32'(sb_dat[0]));
            check("pop_wrap", 32'(out_wrap), 32'(sb_tag[0]));
            void'(sb_dat.pop_front());
            void'(sb_tag.pop_front());
        end
        if (v.rst) begin
            sb_dat.delete();
            sb_tag.delete();
            m_prev = '0;
            m_drop = 1'b0;
        end else if (v.iv) begin
            if (sb_dat.size() < DEPTH) begin
                sb_dat.push_back(v.id);
                sb_tag.push_back(WRAP_EN && (v.id < m_prev));
            end else begin
                m_drop = 1'b1;
            end
            m_prev = v.id;
        end
        @(posedge clk);
        #1;
        if (v.cnt < 0) begin
            exp_cnt = sb_dat.size();
            exp_vld = (sb_dat.size() != 0);
            exp_drp = m_drop;
        end else begin
            exp_cnt = v.cnt;
            exp_vld = v.vld;
            exp_drp = v.drp;
        end
        check("count", 32'(count), 32'(exp_cnt));
        check("out_valid", 32'(out_valid), 32'(exp_vld));
        check("drop", 32'(drop), 32'(exp_drp));
        if (sb_dat.size() > 0) begin
            check("head_data", 32'(out_data), 32'(sb_dat[0]));
            check("head_wrap", 32'(out_wrap), 32'(sb_tag[0]));
        end else begin
            check("empty_wrap", 32'(out_wrap), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_prev = '0; m_drop = 1'b0;

        // Reset, then scenarios 1 and 2.
        vecs.push_back(mk(1, 0, 0,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0, 0));  // ready while empty is ignored
        vecs.push_back(mk(0, 1, 441,   0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1737,  0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0, 0));
        // Scenario 3: overflow drops 100 and sets sticky drop.
        vecs.push_back(mk(0, 1, 441,   0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1737,  0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 5833,  0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 56458, 0, 4, 1, 0));
        vecs.push_back(mk(0, 1, 100,   0, 4, 1, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 1, 3 - i, (i != 3), 1));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0, 0));
        // Scenario 4: full, push and pop together.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 10 * (i + 1), 0, i + 1, 1, 0));
        vecs.push_back(mk(0, 1, 7,     1, 4, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 1, 3 - i, (i != 3), 0));
        // Scenario 5: reset with in_valid mid-stream.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, i + 1, 0, i + 1, 1, 0));
        vecs.push_back(mk(1, 1, 99,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5833,  1, 1, 1, 0));  // empty: push only
        vecs.push_back(mk(0, 0, 0,     1, 0, 0, 0));
        // Scenario 6: roll-over tag.
        vecs.push_back(mk(0, 1, 1048000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 500,   0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i == 0)
                check("reset_out_data", 32'(out_data), 32'd0);
        end

        // Hand-written: explicit roll-over tag expectations after a fresh reset.
        apply(mk(1, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 1, 1048000, 0, 1, 1, 0));
        apply(mk(0, 1, 500, 0, 2, 1, 0));
        check("wrap_first", 32'(out_wrap), 32'd0);
        apply(mk(0, 0, 0, 1, 1, 1, 0));
        check("wrap_second", 32'(out_wrap), 32'(WRAP_EN));
        apply(mk(0, 0, 0, 1, 0, 0, 0));

        // Hand-written: random traffic against the model, including overflow.
        for (int i = 0; i < 200; i++)
            apply(mk(0, ($urandom_range(0, 3) != 0), $urandom_range(0, (1 << WIDTH) - 1),
                     ($urandom_range(0, 2) == 0), -1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
